// File: rtl/bcd_sub_serial_pkg.sv
// Shared definitions for the digit-serial BCD subtractor:
// FSM encodings, BCD digit width and digit-range helper.
package bcd_sub_serial_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int         BCD_W   = 4;
   localparam logic [3:0] BCD_MAX = 4'd9;

   function automatic logic bcd_ok(input logic [BCD_W-1:0] dig);
      return dig <= BCD_MAX;
   endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// One BCD digit of subtraction with borrow: d = a - b - bi, wrapped by +10 on borrow.
module bcd_digit_sub
   import bcd_sub_serial_pkg::*;
(
   input  logic [BCD_W-1:0] a,
   input  logic [BCD_W-1:0] b,
   input  logic             bi,
   output logic [BCD_W-1:0] d,
   output logic             bo
);

   logic [BCD_W:0] t;

   // Operands are 0..9, so t spans -10..9 and bit 4 is the sign.
   always_comb begin
      t  = {1'b0, a} - {1'b0, b} - {{BCD_W{1'b0}}, bi};
      bo = t[BCD_W];
      d  = t[BCD_W] ? t[BCD_W-1:0] + 4'd10 : t[BCD_W-1:0];
   end

endmodule

// File: rtl/bcd_sub_serial.sv
// Digit-serial BCD subtractor: one shared digit slice walks the operands LSD first,
// one digit per cycle, with operands latched on acceptance.
module bcd_sub_serial
   import bcd_sub_serial_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   minuend,
   input  logic [4*DIGITS-1:0]   subtrahend,
   input  logic                  bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   diff,
   output logic                  bout,
   output logic                  invalid
);

   localparam int              IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDXW-1:0] LAST = IDXW'(DIGITS - 1);

   state_t state, state_nx;

   logic [DIGITS-1:0][BCD_W-1:0] a_q, b_q, d_q;
   logic [IDXW-1:0]              idx;
   logic                         borrow;
   logic                         bad;
   logic [BCD_W-1:0]             dig_d;
   logic                         dig_bo;

   always_comb begin
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (!bcd_ok(minuend[BCD_W*i +: BCD_W]) || !bcd_ok(subtrahend[BCD_W*i +: BCD_W]))
            bad = 1'b1;
      end
   end

   bcd_digit_sub u_dig (
      .a  (a_q[idx]),
      .b  (b_q[idx]),
      .bi (borrow),
      .d  (dig_d),
      .bo (dig_bo)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // An invalid request still spends one RUN cycle, so its done lands one edge after acceptance.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (invalid || idx == LAST) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         d_q     <= '0;
         idx     <= '0;
         borrow  <= 1'b0;
         bout    <= 1'b0;
         invalid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  a_q     <= minuend;
                  b_q     <= subtrahend;
                  borrow  <= bin;
                  idx     <= '0;
                  d_q     <= '0;
                  bout    <= 1'b0;
                  invalid <= bad;
               end
            end
            RUN: begin
               if (!invalid) begin
                  d_q[idx] <= dig_d;
                  borrow   <= dig_bo;
                  idx      <= idx + 1'b1;
                  if (idx == LAST) bout <= dig_bo;
               end
            end
            default: ;
         endcase
      end
   end

   assign diff = d_q;
   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_sub_serial.sv
// Randomized self-checking bench for bcd_sub_serial against a decimal-arithmetic model.
module tb_bcd_sub_serial;

   localparam int D = 4;
   localparam int W = 4 * D;

   logic         clk = 1'b0;
   logic         rst, start, bin;
   logic         busy, done, bout, invalid;
   logic [W-1:0] minuend, subtrahend, diff;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bcd_sub_serial #(.DIGITS(D)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .minuend    (minuend),
      .subtrahend (subtrahend),
      .bin        (bin),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .bout       (bout),
      .invalid    (invalid)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Decimal reference: convert to integers, subtract, ten's complement on negative.
   function automatic void ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                                   output logic [W-1:0] d, output logic bo, output logic inv);
      int av, bv, t, p;
      av = 0; bv = 0; p = 1; inv = 1'b0;
      for (int i = D - 1; i >= 0; i--) begin
         av = av * 10 + int'(a[4*i +: 4]);
         bv = bv * 10 + int'(b[4*i +: 4]);
         if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) inv = 1'b1;
      end
      for (int i = 0; i < D; i++) p = p * 10;
      d = '0; bo = 1'b0;
      if (!inv) begin
         t  = av - bv - int'(bi);
         bo = (t < 0);
         if (t < 0) t = t + p;
         for (int i = 0; i < D; i++) begin
            d[4*i +: 4] = 4'(t % 10);
            t = t / 10;
         end
      end
   endfunction

   // Model: m_cnt counts remaining busy cycles; done is the last of them.
   logic [W-1:0] c_d, m_d;
   logic         c_b, c_i, m_b, m_i, m_ev;
   int           m_cnt = 0;
   bit           chk_en = 1'b0;

   always_comb ref_sub(minuend, subtrahend, bin, c_d, c_b, c_i);

   always @(posedge clk) begin
      if (rst) begin
         m_cnt <= 0; m_ev <= 1'b1; m_d <= '0; m_b <= 1'b0; m_i <= 1'b0;
      end else if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 2) m_ev <= 1'b1;
      end else if (start) begin
         m_d <= c_d; m_b <= c_b; m_i <= c_i; m_ev <= 1'b0;
         m_cnt <= c_i ? 2 : D + 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", busy, m_cnt > 0);
         chk("done", done, m_cnt == 1);
         if (m_ev) begin
            chk("diff", diff, m_d);
            chk("bout", bout, m_b);
            chk("invalid", invalid, m_i);
         end
      end
   end

   // Issue one request from an idle negedge; return latency, busy cycles and the done-cycle result.
   task automatic go(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                     input bit scramble, input bit midpulse,
                     output int lat, output int busyc,
                     output logic [W-1:0] d, output logic bo, output logic inv);
      minuend = a; subtrahend = b; bin = bi; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = -1; busyc = 0; d = '0; bo = 1'b0; inv = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (busy) busyc++;
         if (done) begin
            lat = k; d = diff; bo = bout; inv = invalid;
            break;
         end
         if (scramble) begin
            minuend = W'($urandom); subtrahend = W'($urandom); bin = 1'($urandom);
         end
         start = midpulse && (k == 1);
         @(negedge clk);
      end
      start = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int           lat, bc, nd, last, np, pos;
      logic [W-1:0] d, a, b, ed;
      logic         bo, inv, bi, eb, ei;

      rst = 1'b1; start = 1'b0; bin = 1'b0; minuend = '0; subtrahend = '0;

      ref_sub(16'h0042, 16'h0017, 1'b0, d, bo, inv);
      chk("pin_0042_0017", {inv, bo, d}, {2'b00, 16'h0025});
      ref_sub(16'h0000, 16'h0001, 1'b0, d, bo, inv);
      chk("pin_0000_0001", {inv, bo, d}, {2'b01, 16'h9999});
      ref_sub(16'h00A0, 16'h0000, 1'b0, d, bo, inv);
      chk("pin_00A0", {inv, bo, d}, {2'b10, 16'h0000});

      @(negedge clk); @(negedge clk);
      chk_en = 1'b1;
      chk("rst_outs", {busy, done, bout, invalid, diff}, '0);
      rst = 1'b0;

      go(16'h0042, 16'h0017, 1'b0, 1'b0, 1'b0, lat, bc, d, bo, inv);
      chk("lat_0042", lat, 4); chk("busyc_0042", bc, 5);
      chk("res_0042", {inv, bo, d}, {2'b00, 16'h0025});

      go(16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, lat, bc, d, bo, inv);
      chk("res_0000_0001", {inv, bo, d}, {2'b01, 16'h9999});
      go(16'h9999, 16'h9999, 1'b1, 1'b0, 1'b0, lat, bc, d, bo, inv);
      chk("res_9999_bin", {inv, bo, d}, {2'b01, 16'h9999});

      go(16'h0500, 16'h0250, 1'b1, 1'b1, 1'b1, lat, bc, d, bo, inv);
      chk("lat_midstart", lat, 4);
      chk("res_0500", {inv, bo, d}, {2'b00, 16'h0249});

      go(16'h00A0, 16'h0000, 1'b0, 1'b0, 1'b0, lat, bc, d, bo, inv);
      chk("lat_invalid", lat, 1); chk("busyc_invalid", bc, 2);
      chk("res_invalid", {inv, bo, d}, {2'b10, 16'h0000});
      go(16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, lat, bc, d, bo, inv);
      chk("res_clear_inv", {inv, bo, d}, {2'b00, 16'h0001});

      // Reset in the second RUN cycle aborts without a done pulse.
      minuend = 16'h1234; subtrahend = 16'h0567; bin = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("abort_outs", {busy, done, bout, invalid, diff}, '0);
      nd = 0;
      repeat (8) begin @(negedge clk); if (done) nd++; end
      chk("abort_nodone", nd, 0);
      go(16'h1234, 16'h0567, 1'b0, 1'b0, 1'b0, lat, bc, d, bo, inv);
      chk("res_after_abort", {inv, bo, d}, {2'b00, 16'h0667});

      // start held high: back-to-back requests every DIGITS+2 cycles.
      minuend = 16'h0010; subtrahend = 16'h0001; bin = 1'b0; start = 1'b1;
      last = -1; np = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (c == 19) start = 1'b0;
         if (done) begin
            np++;
            chk("b2b_diff", diff, 16'h0009);
            if (last >= 0) chk("b2b_gap", c - last, 6);
            last = c;
         end
      end
      chk("b2b_pulses", np >= 3, 1'b1);

      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < D; i++) begin
            a[4*i +: 4] = 4'($urandom_range(0, 9));
            b[4*i +: 4] = 4'($urandom_range(0, 9));
         end
         if ($urandom_range(0, 7) == 0) begin
            pos = $urandom_range(0, D - 1);
            if ($urandom_range(0, 1) == 0) a[4*pos +: 4] = 4'($urandom_range(10, 15));
            else                           b[4*pos +: 4] = 4'($urandom_range(10, 15));
         end
         bi = 1'($urandom);
         go(a, b, bi, 1'b1, bit'($urandom_range(0, 1)), lat, bc, d, bo, inv);
         ref_sub(a, b, bi, ed, eb, ei);
         chk("rnd_lat", lat, ei ? 1 : D);
         chk("rnd_res", {inv, bo, d}, {ei, eb, ed});
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
